// File: rtl/ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctrl_pkg : shared types, duty defaults and saturating step helper
// Rev 1.0
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef logic [5:0] duty_t;

    localparam duty_t c_duty_min  = 6'd8;
    localparam duty_t c_duty_max  = 6'd56;
    localparam duty_t c_duty_init = 6'd32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Widened to 7 bits so a MAX of 63 cannot wrap and a MIN of 0 cannot underflow.
    function automatic duty_t duty_next(input duty_t cur, input logic inc, input logic dec,
                                        input duty_t lo, input duty_t hi);
        logic [6:0] cur_w;
        logic [6:0] wide;
        cur_w = {1'b0, cur};
        wide  = cur_w;
        if (inc && !dec)
            wide = ((cur_w + 7'd1) > {1'b0, hi}) ? {1'b0, hi} : (cur_w + 7'd1);
        else if (dec && !inc)
            wide = (cur_w <= {1'b0, lo}) ? {1'b0, lo} : (cur_w - 7'd1);
        return wide[5:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_conditioner : synchroniser, debouncer and hold-to-repeat step strobe
// Rev 1.0
// ---------------------------------------------------------------------------
module btn_conditioner import ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic pulse,
    output logic level
);

    localparam int c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_tmr_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    logic               sync1_q, sync2_q;
    logic               level_q, level_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [c_tmr_w-1:0] tmr_q, tmr_d;
    rpt_state_t         state_q, state_d;
    logic               w_active;
    logic               w_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            state_q <= IDLE;
        end else begin
            sync1_q <= i_btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == c_cnt_w'(DEBOUNCE_CYCLES - 1))
                level_d = ~level_q;
            else
                cnt_d = cnt_q + c_cnt_w'(1);
        end
    end

    // A release accepted this cycle already kills the strobe, not one cycle later.
    assign w_active = level_q & level_d;

    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        if (!w_active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = DELAY;
                DELAY: begin
                    if (tmr_q == c_tmr_w'(REPEAT_DELAY - 1))
                        state_d = REPEAT;
                    else
                        tmr_d = tmr_q + c_tmr_w'(1);
                end
                REPEAT: begin
                    if (tmr_q != c_tmr_w'(REPEAT_RATE - 1))
                        tmr_d = tmr_q + c_tmr_w'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        w_pulse = 1'b0;
        if (w_active) begin
            case (state_q)
                IDLE:    w_pulse = 1'b1;
                DELAY:   w_pulse = (tmr_q == c_tmr_w'(REPEAT_DELAY - 1));
                REPEAT:  w_pulse = (tmr_q == c_tmr_w'(REPEAT_RATE - 1));
                default: w_pulse = 1'b0;
            endcase
        end
    end

    assign pulse = w_pulse;
    assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/btn_duty_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_duty_ctrl : four conditioned buttons driving saturating X/Y duty registers
// Rev 1.0
// ---------------------------------------------------------------------------
module btn_duty_ctrl import ctrl_pkg::*; #(
    parameter int    DEBOUNCE_CYCLES = 1_000_000,
    parameter int    REPEAT_DELAY    = 25_000_000,
    parameter int    REPEAT_RATE     = 5_000_000,
    parameter duty_t DUTY_MIN        = c_duty_min,
    parameter duty_t DUTY_MAX        = c_duty_max,
    parameter duty_t DUTY_INIT       = c_duty_init
) (
    input  logic       sysclk,
    input  logic       Reset_Sw,
    input  logic       Bt_Up_Raw,
    input  logic       Bt_Down_Raw,
    input  logic       Bt_Left_Raw,
    input  logic       Bt_Right_Raw,
    output logic [5:0] Duty_X,
    output logic [5:0] Duty_Y,
    output logic       Bt_Up,
    output logic       Bt_Down,
    output logic       Bt_Left,
    output logic       Bt_Right
);

    // Bit order used throughout: 0 = Up, 1 = Down, 2 = Left, 3 = Right.
    logic       rst_meta_q, rst_sync_q;
    logic [3:0] w_raw, w_strobe, w_level, w_step;
    logic [3:0] pulse_q, pulse_d;
    duty_t      duty_x_q, duty_x_d;
    duty_t      duty_y_q, duty_y_d;

    // Asserts immediately, releases two clocks after Reset_Sw falls.
    always_ff @(posedge sysclk or posedge Reset_Sw) begin
        if (Reset_Sw) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign w_raw = {Bt_Right_Raw, Bt_Left_Raw, Bt_Down_Raw, Bt_Up_Raw};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_cond (
            .clk       (sysclk),
            .rst       (rst_sync_q),
            .i_btn_raw (w_raw[i]),
            .pulse     (w_strobe[i]),
            .level     (w_level[i])
        );
    end

    assign w_step = w_strobe & w_level;

    always_comb begin
        pulse_d  = w_step;
        duty_x_d = duty_next(duty_x_q, w_step[3], w_step[2], DUTY_MIN, DUTY_MAX);
        duty_y_d = duty_next(duty_y_q, w_step[0], w_step[1], DUTY_MIN, DUTY_MAX);
    end

    always_ff @(posedge sysclk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            pulse_q  <= '0;
            duty_x_q <= DUTY_INIT;
            duty_y_q <= DUTY_INIT;
        end else begin
            pulse_q  <= pulse_d;
            duty_x_q <= duty_x_d;
            duty_y_q <= duty_y_d;
        end
    end

    assign Duty_X   = duty_x_q;
    assign Duty_Y   = duty_y_q;
    assign Bt_Up    = pulse_q[0];
    assign Bt_Down  = pulse_q[1];
    assign Bt_Left  = pulse_q[2];
    assign Bt_Right = pulse_q[3];

endmodule
`default_nettype wire

// File: tb/tb_btn_duty_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_btn_duty_ctrl : table vectors, corner sequences and random hold patterns
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_btn_duty_ctrl;

    localparam int D     = 4;
    localparam int RD    = 20;
    localparam int RR    = 8;
    localparam int DMIN  = 8;
    localparam int DMAX  = 56;
    localparam int DINIT = 32;

    logic       clk = 1'b0;
    logic       rst_sw;
    logic       up_raw, dn_raw, lf_raw, rt_raw;
    logic [5:0] duty_x, duty_y;
    logic       bt_up, bt_dn, bt_lf, bt_rt;
    logic [3:0] dp;

    always #5 clk = ~clk;

    btn_duty_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .DUTY_MIN        (6'd8),
        .DUTY_MAX        (6'd56),
        .DUTY_INIT       (6'd32)
    ) dut (
        .sysclk       (clk),
        .Reset_Sw     (rst_sw),
        .Bt_Up_Raw    (up_raw),
        .Bt_Down_Raw  (dn_raw),
        .Bt_Left_Raw  (lf_raw),
        .Bt_Right_Raw (rt_raw),
        .Duty_X       (duty_x),
        .Duty_Y       (duty_y),
        .Bt_Up        (bt_up),
        .Bt_Down      (bt_dn),
        .Bt_Left      (bt_lf),
        .Bt_Right     (bt_rt)
    );

    assign dp = {bt_rt, bt_lf, bt_dn, bt_up};

    int n_vec = 0;
    int n_err = 0;
    int pcnt[4];

    // Reference: raw seen two samples late, accepted after D consecutive
    // disagreeing samples, step on hold times 0, RD, RD+RR, RD+2*RR, ...
    logic [3:0] m_hist[$];
    logic [3:0] m_acc;
    int         m_run[4];
    int         m_h[4];
    int         m_x, m_y;
    logic [3:0] m_pulse;
    bit         model_on;

    typedef struct {
        logic [3:0] raw;
        int         hold;
        int         n_up, n_dn, n_lf, n_rt;
        int         x, y;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_back(4'b0);
        m_hist.push_back(4'b0);
        m_acc   = 4'b0;
        m_pulse = 4'b0;
        m_x     = DINIT;
        m_y     = DINIT;
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
            m_h[i]   = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] seen;
        logic       pre;
        int         netx, nety;
        m_hist.push_back(r);
        seen = m_hist.pop_front();
        for (int i = 0; i < 4; i++) begin
            pre = m_acc[i];
            if (seen[i] != m_acc[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_acc[i] = ~m_acc[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_pulse[i] = pre && m_acc[i] &&
                         (m_h[i] == 0 || (m_h[i] >= RD && (m_h[i] - RD) % RR == 0));
            m_h[i] = (pre && m_acc[i]) ? m_h[i] + 1 : 0;
        end
        netx = int'(m_pulse[3]) - int'(m_pulse[2]);
        nety = int'(m_pulse[0]) - int'(m_pulse[1]);
        if (netx > 0) m_x = (m_x + 1 > DMAX) ? DMAX : m_x + 1;
        if (netx < 0) m_x = (m_x - 1 < DMIN) ? DMIN : m_x - 1;
        if (nety > 0) m_y = (m_y + 1 > DMAX) ? DMAX : m_y + 1;
        if (nety < 0) m_y = (m_y - 1 < DMIN) ? DMIN : m_y - 1;
    endtask

    // Called at a negedge: drive, let one rising edge pass, sample on the next negedge.
    task automatic tick(input logic [3:0] r);
        {rt_raw, lf_raw, dn_raw, up_raw} = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        for (int i = 0; i < 4; i++) pcnt[i] += int'(dp[i]);
        if (model_on)
            check("cycle", {20'd0, dp, duty_x, duty_y}, {20'd0, m_pulse, 6'(m_x), 6'(m_y)});
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 4; i++) pcnt[i] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t;
        int         seen_at;
        logic [3:0] r;
        int         hold;

        tbl[0] = '{4'b1000,  10, 0,  0, 0,  1, 33, 32};
        tbl[1] = '{4'b0100,   3, 0,  0, 0,  0, 33, 32};
        tbl[2] = '{4'b0010, 100, 0, 11, 0,  0, 33, 21};
        tbl[3] = '{4'b0010, 200, 0, 24, 0,  0, 33,  8};
        tbl[4] = '{4'b0011,  10, 1,  1, 0,  0, 33,  8};
        tbl[5] = '{4'b1001,  30, 3,  0, 0,  3, 36, 11};
        tbl[6] = '{4'b0100,  60, 0,  0, 6,  0, 30, 11};
        tbl[7] = '{4'b1111,  10, 1,  1, 1,  1, 30, 11};
        tbl[8] = '{4'b1000, 400, 0,  0, 0, 49, 56, 11};

        rst_sw = 1'b1;
        {rt_raw, lf_raw, dn_raw, up_raw} = 4'b0;
        model_on = 1'b1;
        model_reset();
        clr_cnt();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {20'd0, dp, duty_x, duty_y}, {20'd0, 4'b0, 6'd32, 6'd32});
        rst_sw = 1'b0;

        repeat (100) tick(4'b0);
        check("idle_x", 32'(duty_x), 32'(DINIT));
        check("idle_y", 32'(duty_y), 32'(DINIT));

        for (int k = 0; k < 9; k++) begin
            clr_cnt();
            repeat (tbl[k].hold) tick(tbl[k].raw);
            repeat (12) tick(4'b0);
            check("tbl_up_pulses", pcnt[0], tbl[k].n_up);
            check("tbl_dn_pulses", pcnt[1], tbl[k].n_dn);
            check("tbl_lf_pulses", pcnt[2], tbl[k].n_lf);
            check("tbl_rt_pulses", pcnt[3], tbl[k].n_rt);
            check("tbl_duty_x", 32'(duty_x), tbl[k].x);
            check("tbl_duty_y", 32'(duty_y), tbl[k].y);
        end

        // Up bouncing with 2-cycle periods, then a stable hold.
        clr_cnt();
        for (int i = 0; i < 8; i++) tick((i % 4) < 2 ? 4'b0001 : 4'b0000);
        repeat (10) tick(4'b0001);
        repeat (12) tick(4'b0);
        check("bounce_up_pulses", pcnt[0], 1);
        check("bounce_duty_y", 32'(duty_y), 12);

        for (int s = 0; s < 40; s++) begin
            r    = 4'($urandom_range(15, 0));
            hold = $urandom_range(40, 1);
            repeat (hold) tick(r);
        end
        repeat (12) tick(4'b0);

        // Reset mid-hold of Left; the held button must re-qualify from scratch.
        model_on = 1'b0;
        seen_at  = -1;
        for (int i = 0; i < 50 && seen_at < 0; i++) begin
            tick(4'b0100);
            if (bt_lf) seen_at = i;
        end
        check("left_first_pulse_seen", 32'(seen_at >= 0), 32'd1);
        repeat (5) tick(4'b0100);
        rst_sw = 1'b1;
        #1;
        check("async_reset", {20'd0, dp, duty_x, duty_y}, {20'd0, 4'b0, 6'd32, 6'd32});
        repeat (3) tick(4'b0100);
        check("held_in_reset", {20'd0, dp, duty_x, duty_y}, {20'd0, 4'b0, 6'd32, 6'd32});
        rst_sw  = 1'b0;
        seen_at = -1;
        t       = 0;
        while (seen_at < 0 && t < 30) begin
            t++;
            tick(4'b0100);
            if (bt_lf) begin
                seen_at = t;
                check("post_reset_duty_x", 32'(duty_x), 31);
            end
        end
        check("post_reset_pulse_found", 32'(seen_at >= 0), 32'd1);
        check("post_reset_pulse_window",
              32'(seen_at >= D + 2 && seen_at <= D + 5), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
